difftest_fp_wb_serializer: RTL and testbench

Collects floating-point register-file writeback events from up to NUM_PORTS parallel writeback ports per cycle. It buffers them in a small FIFO and replays them one event per cycle, in program-port order, to the difftest FP-writeback reporter. It sits directly upstream of that reporter, and its output bundle (enable, valid, address, data, coreid) connects to it one-to-one. The core never stalls on difftest, so overflow is detected and flagged, never back-pressured.

---
 rtl/difftest_fp_wb_serializer_if.sv | 37 +++
 rtl/difftest_fp_wb_serializer.sv | 102 ++++++++++
 tb/tb_difftest_fp_wb_serializer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/difftest_fp_wb_serializer_if.sv
// Writeback-side and reporter-side signal bundle of the FP writeback serializer.
// slave = serializer view, master = producer/consumer (core + reporter) view.
interface difftest_fp_wb_serializer_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 64
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS*ADDR_W-1:0] in_address;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [7:0]                  coreid;
  logic                        out_ready;

  logic                        out_enable;
  logic                        out_valid;
  logic [ADDR_W-1:0]           out_address;
  logic [DATA_W-1:0]           out_data;
  logic [7:0]                  out_coreid;
  logic [OCC_W-1:0]            occupancy;
  logic                        overflow;
  logic [15:0]                 drop_count;

  modport slave (
    input  in_valid, in_address, in_data, coreid, out_ready,
    output out_enable, out_valid, out_address, out_data, out_coreid,
           occupancy, overflow, drop_count
  );

  modport master (
    output in_valid, in_address, in_data, coreid, out_ready,
    input  out_enable, out_valid, out_address, out_data, out_coreid,
           occupancy, overflow, drop_count
  );
endinterface

// File: rtl/difftest_fp_wb_serializer.sv
// Buffers up to NUM_PORTS FP writeback events per cycle and replays them one per
// cycle in port order; overflow drops a whole cycle's events and is flagged, never stalled.
module difftest_fp_wb_serializer #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  difftest_fp_wb_serializer_if.slave     io
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_q, drop_d;
  logic [7:0]        coreid_q;

  logic              pop;
  logic              accept;
  logic [OCC_W-1:0]  k;
  logic [OCC_W:0]    free;
  logic [PTR_W-1:0]  slot;
  logic [16:0]       drop_sum;

  always_comb begin
    pop = (occ_q != '0) && io.out_ready;

    k = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      k = k + OCC_W'(io.in_valid[i]);
    end

    // A pop in the same cycle frees its slot for this cycle's pushes.
    free   = (OCC_W+1)'(DEPTH) - {1'b0, occ_q} + (OCC_W+1)'(pop);
    accept = ({1'b0, k} <= free);

    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    slot       = wr_ptr_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (accept && io.in_valid[i]) begin
        addr_mem_d[slot] = io.in_address[i*ADDR_W +: ADDR_W];
        data_mem_d[slot] = io.in_data[i*DATA_W +: DATA_W];
        slot             = slot + PTR_W'(1);
      end
    end

    wr_ptr_d   = accept ? slot : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    occ_d      = occ_q + (accept ? k : '0) - OCC_W'(pop);
    overflow_d = overflow_q | ~accept;

    drop_sum = {1'b0, drop_q} + 17'(k);
    drop_d   = drop_q;
    if (!accept) begin
      drop_d = drop_sum[16] ? '1 : drop_sum[15:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      coreid_q   <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      coreid_q   <= io.coreid;
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clock) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign io.out_valid   = (occ_q != '0);
  assign io.out_enable  = (occ_q != '0);
  assign io.out_address = addr_mem_q[rd_ptr_q];
  assign io.out_data    = data_mem_q[rd_ptr_q];
  assign io.out_coreid  = coreid_q;
  assign io.occupancy   = occ_q;
  assign io.overflow    = overflow_q;
  assign io.drop_count  = drop_q;
endmodule

// File: tb/tb_difftest_fp_wb_serializer.sv
// Directed self-checking bench for difftest_fp_wb_serializer (NUM_PORTS=2, DEPTH=8).
module tb_difftest_fp_wb_serializer;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  difftest_fp_wb_serializer_if #(.NUM_PORTS(2), .DEPTH(8), .ADDR_W(8), .DATA_W(64)) bus ();

  difftest_fp_wb_serializer #(
    .NUM_PORTS(2), .DEPTH(8), .ADDR_W(8), .DATA_W(64)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] a0, input logic [63:0] d0,
                       input logic [7:0] a1, input logic [63:0] d1);
    bus.in_valid   = v;
    bus.in_address = {a1, a0};
    bus.in_data    = {d1, d0};
  endtask

  task automatic idle();
    drive(2'b00, 8'h00, 64'h0, 8'h00, 64'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset         = 1'b0;
    bus.coreid    = 8'h5A;
    bus.out_ready = 1'b1;
    idle();
    #2;
    check_eq("rst_valid",    64'(bus.out_valid),  64'h0);
    check_eq("rst_enable",   64'(bus.out_enable), 64'h0);
    check_eq("rst_occ",      64'(bus.occupancy),  64'h0);
    check_eq("rst_overflow", 64'(bus.overflow),   64'h0);
    check_eq("rst_drops",    64'(bus.drop_count), 64'h0);
    check_eq("rst_coreid",   64'(bus.out_coreid), 64'h0);
    step();
    step();
    reset = 1'b1;
    step();
    check_eq("coreid_pass", 64'(bus.out_coreid), 64'h5A);

    // single event
    drive(2'b01, 8'h05, 64'h3FF0000000000000, 8'h00, 64'h0);
    step();
    idle();
    check_eq("single_valid",  64'(bus.out_valid),   64'h1);
    check_eq("single_enable", 64'(bus.out_enable),  64'h1);
    check_eq("single_addr",   64'(bus.out_address), 64'h05);
    check_eq("single_data",   bus.out_data,         64'h3FF0000000000000);
    step();
    check_eq("single_gone",   64'(bus.out_valid),   64'h0);

    // two ports in one cycle
    drive(2'b11, 8'h01, 64'hA, 8'h02, 64'hB);
    step();
    idle();
    check_eq("pair_occ",   64'(bus.occupancy),   64'h2);
    check_eq("pair_addr0", 64'(bus.out_address), 64'h01);
    check_eq("pair_data0", bus.out_data,         64'hA);
    step();
    check_eq("pair_addr1", 64'(bus.out_address), 64'h02);
    check_eq("pair_data1", bus.out_data,         64'hB);
    check_eq("pair_occ1",  64'(bus.occupancy),   64'h1);
    step();
    check_eq("pair_gone",  64'(bus.out_valid),   64'h0);

    // only port 1 valid
    drive(2'b10, 8'h77, 64'h77, 8'h1F, 64'h1234);
    step();
    idle();
    check_eq("sparse_occ",  64'(bus.occupancy),   64'h1);
    check_eq("sparse_addr", 64'(bus.out_address), 64'h1F);
    check_eq("sparse_data", bus.out_data,         64'h1234);
    step();
    check_eq("sparse_gone", 64'(bus.out_valid),   64'h0);

    // fill and overflow: 5 cycles of 2 with no consumer
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(2'b11, 8'(8'h10 + 2*c), 64'hC000_0000_0000_0000 | 64'(8'h10 + 2*c),
                   8'(8'h11 + 2*c), 64'hC000_0000_0000_0000 | 64'(8'h11 + 2*c));
      step();
    end
    idle();
    check_eq("fill_occ",      64'(bus.occupancy),  64'h8);
    check_eq("fill_overflow", 64'(bus.overflow),   64'h1);
    check_eq("fill_drops",    64'(bus.drop_count), 64'h2);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check_eq("drain_addr", 64'(bus.out_address), 64'(8'h10 + j));
      check_eq("drain_data", bus.out_data, 64'hC000_0000_0000_0000 | 64'(8'h10 + j));
      step();
    end
    check_eq("drain_empty",    64'(bus.out_valid), 64'h0);
    check_eq("overflow_stick", 64'(bus.overflow),  64'h1);

    // reset with 5 entries buffered
    bus.out_ready = 1'b0;
    drive(2'b11, 8'h30, 64'h30, 8'h31, 64'h31); step();
    drive(2'b11, 8'h32, 64'h32, 8'h33, 64'h33); step();
    drive(2'b01, 8'h34, 64'h34, 8'h00, 64'h0);  step();
    idle();
    check_eq("pre_rst_occ", 64'(bus.occupancy), 64'h5);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_valid",    64'(bus.out_valid),  64'h0);
    check_eq("mid_rst_occ",      64'(bus.occupancy),  64'h0);
    check_eq("mid_rst_overflow", 64'(bus.overflow),   64'h0);
    check_eq("mid_rst_drops",    64'(bus.drop_count), 64'h0);
    step();
    reset = 1'b1;
    drive(2'b01, 8'h42, 64'h42, 8'h00, 64'h0);
    step();
    idle();
    check_eq("post_rst_valid", 64'(bus.out_valid),   64'h1);
    check_eq("post_rst_addr",  64'(bus.out_address), 64'h42);
    check_eq("post_rst_occ",   64'(bus.occupancy),   64'h1);

    // fill to 8 behind 0x42: 0x50..0x56
    drive(2'b11, 8'h50, 64'h50, 8'h51, 64'h51); step();
    drive(2'b11, 8'h52, 64'h52, 8'h53, 64'h53); step();
    drive(2'b11, 8'h54, 64'h54, 8'h55, 64'h55); step();
    drive(2'b01, 8'h56, 64'h56, 8'h00, 64'h0);  step();
    idle();
    check_eq("full_occ", 64'(bus.occupancy), 64'h8);

    // full + pop + push of one fits
    bus.out_ready = 1'b1;
    drive(2'b01, 8'h60, 64'h60, 8'h00, 64'h0);
    step();
    check_eq("fullpop_occ",      64'(bus.occupancy),   64'h8);
    check_eq("fullpop_overflow", 64'(bus.overflow),    64'h0);
    check_eq("fullpop_drops",    64'(bus.drop_count),  64'h0);
    check_eq("fullpop_head",     64'(bus.out_address), 64'h50);

    // full + pop + push of two does not fit
    drive(2'b11, 8'h70, 64'h70, 8'h71, 64'h71);
    step();
    idle();
    check_eq("fulldrop_occ",      64'(bus.occupancy),  64'h7);
    check_eq("fulldrop_overflow", 64'(bus.overflow),   64'h1);
    check_eq("fulldrop_drops",    64'(bus.drop_count), 64'h2);
    for (int j = 0; j < 6; j++) begin
      check_eq("fp_drain_addr", 64'(bus.out_address), 64'(8'h51 + j));
      step();
    end
    check_eq("last_addr", 64'(bus.out_address), 64'h60);
    check_eq("last_occ",  64'(bus.occupancy),   64'h1);

    // occupancy 1: pop plus push of one keeps valid high
    drive(2'b01, 8'h61, 64'h61, 8'h00, 64'h0);
    step();
    idle();
    check_eq("swap_valid", 64'(bus.out_valid),   64'h1);
    check_eq("swap_addr",  64'(bus.out_address), 64'h61);
    check_eq("swap_data",  bus.out_data,         64'h61);
    check_eq("swap_occ",   64'(bus.occupancy),   64'h1);
    step();
    check_eq("swap_gone",  64'(bus.out_valid),   64'h0);

    // drop counter saturation: 2 already counted, fill then drop pairs
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 8'h80, 64'h80, 8'h81, 64'h81);
      step();
    end
    check_eq("sat_full", 64'(bus.occupancy), 64'h8);
    for (int c = 0; c < 32766; c++) begin
      step();
    end
    check_eq("sat_near", 64'(bus.drop_count), 64'hFFFE);
    step();
    check_eq("sat_hit",  64'(bus.drop_count), 64'hFFFF);
    step();
    idle();
    check_eq("sat_hold", 64'(bus.drop_count), 64'hFFFF);
    check_eq("sat_occ",  64'(bus.occupancy),  64'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
